// File: rtl/burst_ecc_ram_pkg.sv
// Shared definitions for the burst ECC RAM: parity-bit sizing, operation codes
// and FSM state encoding.
package burst_ecc_ram_pkg;

  // Smallest P with 2^P >= data_width + P + 1 (Hamming bits, excluding overall parity)
  function automatic int ecc_parity_bits(input int data_width);
    int p;
    p = 1;
    while ((2 ** p) < (data_width + p + 1)) p++;
    return p;
  endfunction

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_WRITE  = 2'b10;
  localparam logic [1:0] OP_REJECT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10
  } state_e;

endpackage

// File: rtl/burst_ecc_ram_codec.sv
// Combinational SECDED codec. Codeword bit k (k >= 1) is Hamming position k,
// parity bits sit at power-of-two positions, and bit 0 is the overall parity.
module secded_codec
  import burst_ecc_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int P  = ecc_parity_bits(DATA_WIDTH),
  localparam int N  = DATA_WIDTH + P,
  localparam int CW = N + 1
) (
  input  logic [DATA_WIDTH-1:0] enc_data,
  output logic [CW-1:0]         enc_code,
  input  logic [CW-1:0]         dec_code,
  output logic [DATA_WIDTH-1:0] dec_data,
  output logic                  dec_single,
  output logic                  dec_double
);

  always_comb begin
    int j;
    logic par;
    enc_code = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      if ((k & (k - 1)) != 0) begin
        enc_code[k] = enc_data[j];
        j++;
      end
    end
    for (int i = 0; i < P; i++) begin
      par = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (((k >> i) & 1) == 1) par = par ^ enc_code[k];
      end
      enc_code[1 << i] = par;
    end
    enc_code[0] = ^enc_code[N:1];
  end

  always_comb begin
    int j;
    logic [P-1:0] syn;
    logic ovr;
    logic [CW-1:0] fixed;
    syn = '0;
    for (int i = 0; i < P; i++) begin
      for (int k = 1; k <= N; k++) begin
        if (((k >> i) & 1) == 1) syn[i] = syn[i] ^ dec_code[k];
      end
    end
    ovr        = ^dec_code;
    fixed      = dec_code;
    dec_single = 1'b0;
    dec_double = 1'b0;
    // Odd overall parity means one flip; syndrome 0 points at the parity bit itself
    if (ovr) begin
      if (int'(syn) <= N) begin
        dec_single = 1'b1;
        fixed[syn] = ~fixed[syn];
      end else begin
        dec_double = 1'b1;
      end
    end else if (syn != '0) begin
      dec_double = 1'b1;
    end
    dec_data = '0;
    j = 0;
    for (int k = 1; k <= N; k++) begin
      if ((k & (k - 1)) != 0) begin
        dec_data[j] = fixed[k];
        j++;
      end
    end
  end

endmodule

// File: rtl/burst_ecc_ram.sv
// Single-port SECDED-protected register RAM with read/write bursts, per-bit
// write mask, global write protect and codeword error injection.
module burst_ecc_ram
  import burst_ecc_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    DEPTH          = 16,
  parameter int                    MAX_BURST      = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter int                    CORR_CNT_WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AW-1:0]             req_addr,
  input  logic [LW-1:0]             req_len,
  input  logic                      write_protect,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH-1:0]     wr_mask,
  input  logic [1:0]                err_inject,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      ecc_corr,
  output logic                      ecc_uncorr,
  output logic [CORR_CNT_WIDTH-1:0] corr_count,
  output logic                      busy,
  output logic [AW-1:0]             current_address,
  output logic [1:0]                last_operation
);

  localparam int CW = DATA_WIDTH + ecc_parity_bits(DATA_WIDTH) + 1;

  state_e state, state_nxt;

  logic [CW-1:0]         mem [DEPTH];
  logic [AW-1:0]         addr;
  logic [LW-1:0]         beats_left;
  logic [LW-1:0]         eff_len;
  logic                  accept, wr_beat, rd_load, rd_done;
  logic [AW-1:0]         rd_sel;
  logic [CW-1:0]         inj_mask;
  logic [CW-1:0]         init_code;
  logic [CW-1:0]         wr_code;
  logic [DATA_WIDTH-1:0] wr_old, merged, rd_dec;
  logic                  wr_single, wr_double, rd_single, rd_double;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    wr_beat   = 1'b0;
    rd_load   = 1'b0;
    rd_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_we) begin
            state_nxt = write_protect ? ST_IDLE : ST_WRITE;
          end else begin
            state_nxt = ST_READ;
            rd_load   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_beat = 1'b1;
          if (beats_left == LW'(1)) state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_valid && rd_ready) begin
          if (beats_left == '0) begin
            rd_done   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if (req_len == '0)                  eff_len = LW'(1);
    else if (req_len > LW'(MAX_BURST))  eff_len = LW'(MAX_BURST);
    else                                eff_len = req_len;
  end

  always_comb begin
    case (err_inject)
      2'b01:   inj_mask = CW'(1);
      2'b10:   inj_mask = CW'(3);
      default: inj_mask = '0;
    endcase
  end

  // First read beat is fetched straight from the request address at acceptance
  assign rd_sel = (state == ST_IDLE) ? req_addr : addr;
  assign merged = (wr_old & ~wr_mask) | (wr_data & wr_mask);

  secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_wr_codec (
    .enc_data   (merged),
    .enc_code   (wr_code),
    .dec_code   (mem[addr]),
    .dec_data   (wr_old),
    .dec_single (wr_single),
    .dec_double (wr_double)
  );

  // The read path only decodes, so its encoder half supplies the reset codeword
  secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_rd_codec (
    .enc_data   (INIT_VALUE),
    .enc_code   (init_code),
    .dec_code   (mem[rd_sel]),
    .dec_data   (rd_dec),
    .dec_single (rd_single),
    .dec_double (rd_double)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_code;
    end else if (wr_beat) begin
      mem[addr] <= wr_code ^ inj_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr            <= '0;
      beats_left      <= '0;
      current_address <= '0;
      last_operation  <= OP_NONE;
      rd_valid        <= 1'b0;
      rd_data         <= '0;
      ecc_corr        <= 1'b0;
      ecc_uncorr      <= 1'b0;
      corr_count      <= '0;
    end else begin
      ecc_corr   <= 1'b0;
      ecc_uncorr <= 1'b0;
      if (accept) begin
        if (req_we) begin
          addr           <= req_addr;
          beats_left     <= eff_len;
          last_operation <= write_protect ? OP_REJECT : OP_WRITE;
        end else begin
          addr           <= req_addr + AW'(1);
          beats_left     <= eff_len - LW'(1);
          last_operation <= OP_READ;
        end
      end
      if (wr_beat) begin
        current_address <= addr;
        addr            <= addr + AW'(1);
        beats_left      <= beats_left - LW'(1);
        ecc_corr        <= wr_single;
        ecc_uncorr      <= wr_double;
      end
      if (rd_load) begin
        rd_valid        <= 1'b1;
        rd_data         <= rd_dec;
        current_address <= rd_sel;
        ecc_corr        <= rd_single;
        ecc_uncorr      <= rd_double;
        if (state == ST_READ) begin
          addr       <= addr + AW'(1);
          beats_left <= beats_left - LW'(1);
        end
      end else if (rd_done) begin
        rd_valid <= 1'b0;
      end
      if (((wr_beat && wr_single) || (rd_load && rd_single)) && (corr_count != '1))
        corr_count <= corr_count + CORR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/burst_ecc_ram.md
Name: burst_ecc_ram

Overview:
Parametrised next-generation single-port RAM. It accepts read and write bursts through valid/ready handshakes and applies a per-beat byte/bit write mask. Every stored word is protected with SECDED (Hamming plus overall parity) ECC, and a global write-protect input guards the array. It sits behind bus masters or DMA engines as a local scratch memory, and error injection is built in for verification.

Parameters:
DATA_WIDTH, 8, data bits per word (4..64)
DEPTH, 16, number of words (power of two, >=2)
MAX_BURST, 8, maximum beats per request (power of two)
INIT_VALUE, 0, data value every word holds after reset
CORR_CNT_WIDTH, 8, width of the saturating corrected-error counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_we  in  1  1 = write burst, 0 = read burst
req_addr  in  clog2(DEPTH)  start address
req_len  in  clog2(MAX_BURST)+1  beat count (1..MAX_BURST; 0 treated as 1; >MAX_BURST clamped to MAX_BURST)
write_protect  in  1  when high at acceptance, write requests are rejected
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted when wr_valid & wr_ready
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH  per-bit write enable; 1 = take wr_data
err_inject  in  2  00 none, 01 flip codeword bit 0, 10 flip codeword bits 0 and 1, 11 none; applied to the stored codeword of the current write beat
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat consumed when rd_valid & rd_ready
rd_data  out  DATA_WIDTH  corrected read data
ecc_corr  out  1  one-cycle pulse: single-bit error corrected
ecc_uncorr  out  1  one-cycle pulse: double-bit error detected
corr_count  out  CORR_CNT_WIDTH  saturating count of ecc_corr pulses
busy  out  1  high in any state other than IDLE
current_address  out  clog2(DEPTH)  address of the current or last beat
last_operation  out  2  00 none, 01 read, 10 write, 11 rejected

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE. Every array word is loaded with encode(INIT_VALUE). All outputs are 0 except req_ready=1. Reset mid-burst abandons the burst and discards remaining beats.
- The array is a register array. Each word holds DATA_WIDTH data bits plus P Hamming bits plus 1 overall parity bit. P is the minimum value with 2^P >= DATA_WIDTH+P+1; for DATA_WIDTH=8, P=4, giving a 13-bit codeword.
- FSM states: IDLE, WRITE, READ.
- IDLE: req_ready=1. On acceptance, latch addr and len.
  - If req_we & write_protect: stay in IDLE, set last_operation=11, do not consume any write beats.
  - If req_we and not protected: go to WRITE, last_operation=10.
  - Otherwise go to READ, last_operation=01.
- WRITE: wr_ready=1.
  - Each accepted beat performs a combinational read-modify-write: decode the old word, merge data=(dec_old & ~wr_mask)|(wr_data & wr_mask), encode, XOR err_inject, store at the next clk.
  - ecc_corr/ecc_uncorr pulse for errors found in the old word. On an uncorrectable error the write still completes using the merged data.
  - Address increments modulo DEPTH (wraps DEPTH-1 -> 0). After len beats, return to IDLE in the cycle after the last beat.
- READ:
  - The first beat is loaded into the output register in the cycle after acceptance, so rd_valid rises 1 cycle after the request handshake.
  - rd_data and rd_valid hold until rd_ready. On a handshake the next beat loads in the same edge, giving one beat per cycle when rd_ready is held high.
  - ECC pulses fire in the cycle rd_data loads. Reads never write back corrections.
  - Address wraps modulo DEPTH. After the final handshake: rd_valid=0 and the FSM returns to IDLE.
- current_address: updated on every beat. last_operation: updated only on request acceptance.
- corr_count: saturates at all-ones; cleared only by reset.
- Simultaneous events: req_valid is ignored while busy. write_protect is sampled only at acceptance; changing it mid-burst has no effect.

Decomposition:
- Package burst_ecc_ram_pkg holds:
  - function ecc_parity_bits(DATA_WIDTH)
  - op-code localparams OP_NONE, OP_READ, OP_WRITE, OP_REJECT
  - the FSM state enum
- Sub-module secded_codec: purely combinational encode and decode (corrected data, single flag, double flag), instantiated once in the write path and once in the read path.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> all 16 words decode to 0x00; busy=0, req_ready=1, last_operation=00.
- Single write then read: write addr 5 data 0xAA mask 0xFF, then read addr 5 len 1 -> rd_data=0xAA 1 cycle after acceptance; ecc flags 0; last_operation=01.
- Masked burst with wrap: write addr 14 len 4 data 0xFF mask 0x0F over zeroed memory, then read addr 14 len 4 with rd_ready toggling 1,0,1,1 -> words 14,15,0,1 read 0x0F; rd_data stable while rd_ready=0.
- Write protect: write_protect=1, write request addr 3 -> last_operation=11, wr_ready never asserts, word 3 unchanged.
- ECC single error: write addr 2 0x5A with err_inject=01, then read -> rd_data=0x5A, ecc_corr pulse, corr_count=1.
- ECC double error and mid-burst reset: write addr 7 with err_inject=10, then read -> ecc_uncorr pulse, corr_count unchanged. Then start a read len 8 and assert rst_n low after 3 beats -> rd_valid=0 immediately and FSM in IDLE.
